nor_bank: RTL
=============

# nor_bank

Parametrised bank of `WIDTH` independent `FANIN`-input NOR gates, clocked model with per-gate propagation delay counted in enabled clock cycles. Supports two delay modes: transport (every input change propagates) and inertial (pulses shorter than the delay are swallowed). Each gate's output forces to a per-gate initial value while in reset. Used wherever the logic-level model needs deterministic, cycle-accurate gate delay and glitch filtering in a synthesisable, clocked form.

## Interface
Parameters:
- `WIDTH`, 8: number of gates.
- `FANIN`, 4: inputs per gate.
- `DELAY`, 3: propagation delay in enabled cycles, ≥1.
- `IV`, 0: `WIDTH`-bit reset value; bit i is gate i's initial output.
- `INERTIAL`, 0: 0 selects transport mode, 1 selects inertial mode.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  delay tick; state advances only on edges where `en`=1.
- `a`  in  WIDTH*FANIN  gate inputs; gate i uses `a[i*FANIN +: FANIN]`.
- `mask`  in  FANIN  input enable, shared by all gates; a 0 bit removes that input position.
- `y`  out  WIDTH  registered gate outputs.
- `settled`  out  1  no transition pending in any gate.

## Operation
- Target per gate: `t[i] = ~|(a[i*FANIN +: FANIN] & mask)`.
  - `mask`=0 gives `t`=1 for all gates.
- Reset, asynchronous, while `rst`=1:
  - `y` = `IV`.
  - All transport stages = `IV`.
  - All inertial counters = 0.
  - Reset asserted mid-transition discards pending transitions with no residue.
- `en`=0 edge: all state holds, whatever `a` or `mask` does.

Transport mode (`INERTIAL`=0):
- Each gate has a `DELAY`-stage shift register `s[0..DELAY-1]`.
- On each `en` edge: `s[0]` ← `t`, and `s[j]` ← `s[j-1]`.
- `y` = `s[DELAY-1]`.
- Every value of `t` sampled on an `en` edge reaches `y` exactly `DELAY` `en` edges later.
- `settled` = 1 when every stage of every gate equals that gate's current `t`.

Inertial mode (`INERTIAL`=1):
- Each gate has a counter `cnt`, width `$clog2(DELAY+1)`, reset 0.
- On each `en` edge, per gate:
  - If `t`==`y`: `cnt` ← 0. This cancels any pending change.
  - Else if `cnt`==`DELAY-1`: `y` ← `t` and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- `y` changes only after `t` has differed from `y` on `DELAY` consecutive `en` edges.
- A shorter excursion leaves `y` unchanged and resets `cnt`.
- `settled` = 1 when, for every gate, `cnt`==0 and `t`==`y`.

General:
- Gates are fully independent; simultaneous transitions in different gates do not interact.
- `settled` is combinational from state, `a` and `mask`.
- The counter never exceeds `DELAY-1`, so it cannot wrap.

## Timing
- Latency, both modes: `t` stable before `en` edge k appears on `y` after `en` edge k+`DELAY`-1, i.e. `DELAY` enabled edges.
  - `DELAY`=1: `y` follows `t` on the next `en` edge.
- Disabled edges (`en`=0) do not count toward latency.
- Transport mode: a pulse on `t` lasting n ≥ 1 `en` edges appears on `y` lasting n edges, delayed by `DELAY`.
- Inertial mode: a pulse shorter than `DELAY` `en` edges is filtered.
- Inertial mode: a pulse of ≥ `DELAY` edges appears on `y` shortened by nothing; it is delayed by `DELAY`.
- Outputs are glitch-free: `y` is taken directly from flops.
- First `en` edge after `rst` deasserts is the first counted edge.

## Test plan
Parameters for all scenarios: `WIDTH`=4, `FANIN`=2, `DELAY`=3, `IV`=4'b1010.
1. Reset value: hold `rst`=1, `a`=0, `mask`=2'b11 → `y`=4'b1010 immediately.
   - After release with `en`=1, `y`=4'b1111 on the 3rd edge.
   - `settled` goes 0 → 1 on that same edge.
2. Transport latency, `INERTIAL`=0, `en`=1 throughout: gate0 `a` goes 00 → 01 before edge 1 → `y[0]` goes 1 → 0 on edge 3.
   - A 1-edge pulse back to 00 reappears as a 1-edge pulse on `y[0]`, 3 edges later.
3. Inertial filtering, `INERTIAL`=1: gate1 input pulse lasting 2 `en` edges → `y[1]` never changes.
   - A 3-edge pulse toggles `y[1]` at edge 3 and restores it 3 edges after the input returns.
4. Enable gating: toggle `en` 1,0,0,1,1 with a constant input change → `y` updates on the 3rd `en`=1 edge (5th clock).
5. Mask: `a` all 1s, `mask` 11 → 00 → after 3 `en` edges `y`=4'b1111.
6. Async reset mid-transition: assert `rst` between edges 2 and 3 of a pending change → `y`=4'b1010 at once, no clock needed.
   - After release, the change takes a full 3 edges again.

Source files
------------

// File: rtl/nor_bank_if.sv
// Purpose: bundles the nor_bank stimulus (en, a, mask) and observation (y, settled) signals.
// Latency: none; this is wiring only.
// Backpressure: none; the gate bank always accepts its inputs.
//
// master drives en/a/mask and observes y/settled; slave is the gate bank.
interface nor_bank_if #(
    parameter int WIDTH = 8,
    parameter int FANIN = 4
);
    logic                   en;
    logic [WIDTH*FANIN-1:0] a;
    logic [FANIN-1:0]       mask;
    logic [WIDTH-1:0]       y;
    logic                   settled;

    modport master (output en, output a, output mask, input y, input settled);
    modport slave  (input en, input a, input mask, output y, output settled);
endinterface

// File: rtl/nor_bank.sv
// Purpose: bank of WIDTH independent FANIN-input NOR gates with clocked transport or inertial delay.
// Latency: a target value held before enabled edge k shows on y after enabled edge k+DELAY-1.
// Backpressure: none; en=0 freezes all state, and inputs are never stalled.
//
// Ports: clk, rst (async, active-high; forces y to IV and drops pending changes),
//        bus.en (delay tick), bus.a (gate i uses a[i*FANIN +: FANIN]),
//        bus.mask (shared input enable), bus.y (registered outputs),
//        bus.settled (no transition pending in any gate).
module nor_bank #(
    parameter int               WIDTH    = 8,
    parameter int               FANIN    = 4,
    parameter int               DELAY    = 3,
    parameter logic [WIDTH-1:0] IV       = '0,
    parameter int               INERTIAL = 0
) (
    input  logic       clk,
    input  logic       rst,
    nor_bank_if.slave  bus
);

    // Combinational target of every gate; a cleared mask bit removes that input.
    logic [WIDTH-1:0] tgt;

    always_comb begin
        tgt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tgt[i] = ~|(bus.a[i*FANIN +: FANIN] & bus.mask);
        end
    end

    if (INERTIAL == 0) begin : g_transport
        // One shift register per gate, held as DELAY bank-wide words.
        logic [WIDTH-1:0] stage [DELAY];
        logic             settled_tr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < DELAY; j++) begin
                    stage[j] <= IV;
                end
            end else if (bus.en) begin
                stage[0] <= tgt;
                for (int j = 1; j < DELAY; j++) begin
                    stage[j] <= stage[j-1];
                end
            end
        end

        // Nothing pending once every in-flight sample already equals the target.
        always_comb begin
            settled_tr = 1'b1;
            for (int j = 0; j < DELAY; j++) begin
                if (stage[j] != tgt) begin
                    settled_tr = 1'b0;
                end
            end
        end

        assign bus.y       = stage[DELAY-1];
        assign bus.settled = settled_tr;
    end else begin : g_inertial
        localparam int             CW      = $clog2(DELAY + 1);
        localparam logic [CW-1:0]  CNT_MAX = CW'(DELAY - 1);

        logic [WIDTH-1:0] y_q;
        logic [CW-1:0]    cnt [WIDTH];
        logic             settled_in;

        // cnt counts consecutive enabled edges on which the target disagreed
        // with the output; the DELAY-th such edge commits the new value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_q <= IV;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt[i] <= '0;
                end
            end else if (bus.en) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (tgt[i] == y_q[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        y_q[i] <= tgt[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end

        always_comb begin
            settled_in = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                if ((cnt[i] != '0) || (tgt[i] != y_q[i])) begin
                    settled_in = 1'b0;
                end
            end
        end

        assign bus.y       = y_q;
        assign bus.settled = settled_in;
    end

endmodule
